// File: rtl/riot_timer_pkg.sv
// Shared types, address-field positions and prescaler helper for the multi-channel RIOT timer.
package riot_timer_pkg;

    typedef enum logic [1:0] {
        DIV1    = 2'd0,
        DIV8    = 2'd1,
        DIV64   = 2'd2,
        DIV1024 = 2'd3
    } psel_t;

    localparam int CH_HI    = 5;
    localparam int CH_LO    = 4;
    localparam int MODE_BIT = 3;
    localparam int IEN_BIT  = 2;

    // Terminal prescaler count: a tick fires when pcnt reaches this value.
    function automatic logic [9:0] psel_last(psel_t p);
        case (p)
            DIV1:    return 10'd0;
            DIV8:    return 10'd7;
            DIV64:   return 10'd63;
            default: return 10'd1023;
        endcase
    endfunction

endpackage

// File: rtl/riot_timer_multi_if.sv
// 6502-style register port shared by all timer channels.
interface riot_timer_multi_if #(
    parameter int AW = 6
);
    logic          enable;
    logic          we_n;
    logic [AW-1:0] A;
    logic [7:0]    DI;
    logic [7:0]    DO;
    logic          OE;

    modport master (output enable, output we_n, output A, output DI, input DO, input OE);
    modport slave  (input enable, input we_n, input A, input DI, output DO, output OE);
endinterface

// File: rtl/riot_timer_chan.sv
// One interval-timer channel: prescaler, 8-bit down-counter, underflow flag and reload logic.
module riot_timer_chan
    import riot_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_tmr,
    input  logic       wr_mode,
    input  logic       rd_cnt,
    input  logic [7:0] di,
    input  logic [1:0] a_psel,
    input  logic       a_ien,
    output logic [7:0] cnt,
    output logic       flag,
    output logic       ien
);

    logic [7:0] reload;
    psel_t      psel;
    logic [9:0] pcnt;
    logic       mode;
    logic       fast;
    logic       run;
    logic       tick;

    // run keeps a freshly reset channel idle until its first timer write.
    assign tick = run & (fast | (pcnt == psel_last(psel)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 8'h00;
            reload <= 8'h00;
            psel   <= DIV1;
            pcnt   <= 10'd0;
            flag   <= 1'b0;
            ien    <= 1'b0;
            mode   <= 1'b0;
            fast   <= 1'b0;
            run    <= 1'b0;
        end else if (wr_tmr) begin
            cnt    <= di;
            reload <= di;
            psel   <= psel_t'(a_psel);
            pcnt   <= 10'd0;
            ien    <= a_ien;
            flag   <= 1'b0;
            fast   <= 1'b0;
            run    <= 1'b1;
        end else begin
            if (wr_mode)
                mode <= di[0];
            if (rd_cnt) begin
                ien  <= a_ien;
                flag <= 1'b0;
                fast <= 1'b0;
            end
            // Underflow assignments come last so they win over a same-edge read.
            if (tick) begin
                pcnt <= 10'd0;
                if (cnt != 8'h00) begin
                    cnt <= cnt - 8'd1;
                end else begin
                    flag <= 1'b1;
                    if (mode) begin
                        cnt <= reload;
                    end else begin
                        cnt  <= 8'hFF;
                        fast <= 1'b1;
                    end
                end
            end else if (run) begin
                pcnt <= pcnt + 10'd1;
            end
        end
    end

endmodule

// File: rtl/riot_timer_multi.sv
// NCH-channel 6530-style interval timer behind one register port with a combined active-low IRQ.
module riot_timer_multi
    import riot_timer_pkg::*;
#(
    parameter int NCH = 2,
    parameter int AW  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    riot_timer_multi_if.slave    bus,
    output logic                 irq_n,
    output logic [NCH-1:0]       irq_en
);

    logic [AW-1:0]  a;
    logic [1:0]     ch;
    logic           ch_ok;
    logic           acc_wr;
    logic           acc_rd;
    logic [7:0]     rd_data;
    logic [7:0]     cnt [NCH];
    logic [NCH-1:0] flag;
    logic [NCH-1:0] ien;
    logic [NCH-1:0] wr_tmr;
    logic [NCH-1:0] wr_mode;
    logic [NCH-1:0] rd_cnt;

    assign a      = bus.A;
    assign ch     = a[CH_HI:CH_LO];
    assign ch_ok  = ({1'b0, ch} < 3'(NCH));
    assign acc_wr = bus.enable & ~bus.we_n & ch_ok;
    // Reads of a missing channel still complete (OE high) but return zero.
    assign acc_rd = bus.enable & bus.we_n & ~a[MODE_BIT];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic sel;
        assign sel        = (ch == 2'(i));
        assign wr_tmr[i]  = acc_wr & sel & ~a[MODE_BIT];
        assign wr_mode[i] = acc_wr & sel & a[MODE_BIT];
        assign rd_cnt[i]  = acc_rd & ch_ok & sel & ~a[0];

        riot_timer_chan u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_tmr  (wr_tmr[i]),
            .wr_mode (wr_mode[i]),
            .rd_cnt  (rd_cnt[i]),
            .di      (bus.DI),
            .a_psel  (a[1:0]),
            .a_ien   (a[IEN_BIT]),
            .cnt     (cnt[i]),
            .flag    (flag[i]),
            .ien     (ien[i])
        );
    end

    always_comb begin
        rd_data = 8'h00;
        if (ch_ok) begin
            if (a[0]) begin
                rd_data[7]       = |flag;
                rd_data[NCH-1:0] = flag;
            end else begin
                for (int i = 0; i < NCH; i++)
                    if (ch == 2'(i))
                        rd_data = cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.DO <= 8'h00;
            bus.OE <= 1'b0;
            irq_n  <= 1'b1;
        end else begin
            bus.OE <= acc_rd;
            if (acc_rd)
                bus.DO <= rd_data;
            irq_n <= ~|(flag & ien);
        end
    end

    assign irq_en = ien;

endmodule

// File: tb/tb_riot_timer_multi.sv
// Directed bench for riot_timer_multi with NCH=2: one-shot, reload, IRQ masking, collisions and reset.
module tb_riot_timer_multi;

    logic       clk;
    logic       rst_n;
    logic       irq_n;
    logic [1:0] irq_en;
    int         n_tests;
    int         n_fail;

    riot_timer_multi_if #(.AW(6)) bus ();

    riot_timer_multi #(.NCH(2), .AW(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .irq_n  (irq_n),
        .irq_en (irq_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic access(input logic we, input logic [5:0] addr, input logic [7:0] data);
        bus.enable = 1'b1;
        bus.we_n   = we;
        bus.A      = addr;
        bus.DI     = data;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        bus.we_n   = 1'b1;
    endtask

    task automatic wr_timer(input logic [1:0] ch, input logic ie, input logic [1:0] ps, input logic [7:0] v);
        access(1'b0, {ch, 1'b0, ie, ps}, v);
    endtask

    task automatic wr_mode(input logic [1:0] ch, input logic m);
        access(1'b0, {ch, 1'b1, 3'b000}, {7'd0, m});
    endtask

    task automatic rd_cnt(input logic [1:0] ch, input logic ie);
        access(1'b1, {ch, 1'b0, ie, 2'b00}, 8'h00);
    endtask

    task automatic rd_stat(input logic [1:0] ch);
        access(1'b1, {ch, 1'b0, 1'b0, 2'b01}, 8'h00);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.we_n   = 1'b1;
        bus.A      = 6'd0;
        bus.DI     = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_irq_n", {7'd0, irq_n}, 8'h01);
        chk("rst_oe", {7'd0, bus.OE}, 8'h00);
        chk("rst_do", bus.DO, 8'h00);
        chk("rst_irq_en", {6'd0, irq_en}, 8'h00);

        idle(100);
        chk("idle_irq_n", {7'd0, irq_n}, 8'h01);
        chk("idle_oe", {7'd0, bus.OE}, 8'h00);
        rd_stat(2'd0);
        chk("idle_stat_oe", {7'd0, bus.OE}, 8'h01);
        chk("idle_stat_do", bus.DO, 8'h00);
        idle(1);
        chk("oe_drop", {7'd0, bus.OE}, 8'h00);

        // Channel 2 does not exist: write ignored, read gives 0 with OE.
        wr_timer(2'd2, 1'b1, 2'd0, 8'h01);
        rd_stat(2'd2);
        chk("nch_rd_oe", {7'd0, bus.OE}, 8'h01);
        chk("nch_rd_do", bus.DO, 8'h00);
        idle(10);
        rd_stat(2'd0);
        chk("nch_wr_ignored", bus.DO, 8'h00);
        chk("nch_irq_n", {7'd0, irq_n}, 8'h01);

        // Ch0 one-shot: 3 at /8 written at edge W, flag at W+32, irq_n low at W+33.
        wr_timer(2'd0, 1'b1, 2'd1, 8'h03);
        chk("ch0_irq_en", {6'd0, irq_en}, 8'h01);
        idle(31);
        chk("ch0_irq_w31", {7'd0, irq_n}, 8'h01);
        idle(1);
        chk("ch0_irq_w32", {7'd0, irq_n}, 8'h01);
        rd_cnt(2'd0, 1'b1);
        chk("ch0_rd_ff", bus.DO, 8'hFF);
        chk("ch0_irq_w33", {7'd0, irq_n}, 8'h00);
        idle(1);
        chk("ch0_irq_cleared", {7'd0, irq_n}, 8'h01);
        rd_cnt(2'd0, 1'b1);
        chk("ch0_rd_fe", bus.DO, 8'hFE);
        idle(5);
        rd_cnt(2'd0, 1'b1);
        chk("ch0_div8_hold", bus.DO, 8'hFE);
        rd_cnt(2'd0, 1'b1);
        chk("ch0_div8_dec", bus.DO, 8'hFD);

        // Ch1 auto-reload: 4 at /1, period 5.
        wr_mode(2'd1, 1'b1);
        wr_timer(2'd1, 1'b0, 2'd0, 8'h04);
        for (int k = 0; k < 5; k++) begin
            rd_cnt(2'd1, 1'b0);
            chk("ch1_seq", bus.DO, 8'(4 - k));
        end
        rd_stat(2'd1);
        chk("ch1_flag_on_rd_edge", bus.DO, 8'h82);
        rd_cnt(2'd1, 1'b0);
        chk("ch1_reloaded", bus.DO, 8'h03);
        idle(2);
        rd_stat(2'd0);
        chk("ch1_period_pre", bus.DO, 8'h00);
        rd_stat(2'd0);
        chk("ch1_period_set", bus.DO, 8'h82);
        rd_cnt(2'd0, 1'b1);
        chk("ch0_undisturbed_a", bus.DO, 8'hFC);
        idle(1);
        rd_cnt(2'd0, 1'b1);
        chk("ch0_undisturbed_b", bus.DO, 8'hFB);
        chk("ch0_no_irq", {7'd0, irq_n}, 8'h01);

        // Masked interrupt: flag sets but irq_n stays high.
        wr_timer(2'd1, 1'b0, 2'd3, 8'hFF);
        wr_timer(2'd0, 1'b0, 2'd0, 8'h02);
        idle(3);
        chk("mask_irq_pre", {7'd0, irq_n}, 8'h01);
        rd_stat(2'd0);
        chk("mask_stat", bus.DO, 8'h81);
        chk("mask_irq_n", {7'd0, irq_n}, 8'h01);
        chk("mask_irq_en", {6'd0, irq_en}, 8'h00);

        // Write on the underflow edge wins; read on the underflow edge keeps the flag.
        wr_timer(2'd0, 1'b0, 2'd0, 8'h01);
        idle(1);
        wr_timer(2'd0, 1'b0, 2'd0, 8'h05);
        rd_cnt(2'd0, 1'b0);
        chk("wr_win_cnt", bus.DO, 8'h05);
        rd_stat(2'd0);
        chk("wr_win_flag", bus.DO, 8'h00);
        idle(3);
        rd_cnt(2'd0, 1'b0);
        chk("rd_uf_do", bus.DO, 8'h00);
        rd_stat(2'd0);
        chk("rd_uf_flag", bus.DO, 8'h81);

        // Asynchronous reset between edges.
        wr_timer(2'd0, 1'b1, 2'd0, 8'h02);
        idle(4);
        chk("pre_rst_irq", {7'd0, irq_n}, 8'h00);
        chk("pre_rst_irq_en", {6'd0, irq_en}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("async_irq_n", {7'd0, irq_n}, 8'h01);
        chk("async_do", bus.DO, 8'h00);
        chk("async_oe", {7'd0, bus.OE}, 8'h00);
        chk("async_irq_en", {6'd0, irq_en}, 8'h00);
        #1 rst_n = 1'b1;
        idle(20);
        rd_cnt(2'd0, 1'b0);
        chk("post_rst_cnt", bus.DO, 8'h00);
        rd_stat(2'd0);
        chk("post_rst_stat", bus.DO, 8'h00);
        chk("post_rst_irq", {7'd0, irq_n}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
